axi4lite_xbar_nm: RTL and testbench
===================================

Name: axi4lite_xbar_nm

Overview:
- Parametrised shared-bus AXI4-Lite interconnect connecting NM masters to NS slaves; successor of the fixed 2-master/16-slave interconnect used in the SoC top.
- Round-robin arbitration replaces fixed priority, and slaves now return BRESP/RRESP.
- Unmapped addresses complete with DECERR instead of hanging.
- One transaction in flight across the whole fabric.

Parameters:
- NM, 2, number of masters (1..8)
- NS, 16, number of slaves (1..2^SEL_W)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- SEL_W, 4, slave-select bits taken from addr[AW-1 -: SEL_W]
- TIMEOUT_CYC, 255, timeout limit in cycles (used only with the optional feature)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- m_axi_awaddr, m_axi_araddr  input  NM*AW  master addresses, master k at [k*AW +: AW]
- m_axi_wdata  input  NM*DW  master write data
- m_axi_wstrb  input  NM*DW/8  master write strobes
- m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready  input  NM  master valids/readies
- m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid  output  NM  master readies/valids
- m_axi_bresp, m_axi_rresp  output  NM*2  responses to masters
- m_axi_rdata  output  NM*DW  read data to masters
- s_axi_awaddr, s_axi_araddr  output  NS*AW  full master address forwarded unchanged
- s_axi_wdata  output  NS*DW  write data to slaves
- s_axi_wstrb  output  NS*DW/8  write strobes to slaves
- s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready  output  NS  slave valids/readies
- s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid  input  NS  slave readies/valids
- s_axi_bresp, s_axi_rresp  input  NS*2  slave responses
- s_axi_rdata  input  NS*DW  slave read data
- timeout_o  output  1  sticky timeout flag

Behaviour:
- Reset values:
  - FSM = IDLE; rr pointer = 0; timeout_o = 0.
  - All valid/ready outputs = 0; all resp/data outputs = 0.
- Request of master k = arvalid[k] | (awvalid[k] & wvalid[k]). If a master presents both, the read is served first.
- IDLE:
  - Winner = first requesting master at or after the rr pointer, modulo NM.
  - Registered on the clock edge: master index, read/write type, slave index sel = addr[AW-1 -: SEL_W], and unmapped flag (sel >= NS).
  - One cycle of arbitration latency; no ready is asserted in IDLE.
- WADDR:
  - Forward awvalid/wvalid and payload to slave sel; return awready/wready to the master.
  - Track aw_done and w_done independently. Once a channel has handshaken, its forwarded valid is masked.
  - Both done -> WRESP.
- WRESP:
  - Forward bvalid/bresp; return bready.
  - On handshake: -> IDLE, rr pointer = granted+1 (wraps at NM).
- RADDR: forward arvalid/araddr; arready handshake -> RDATA.
- RDATA: forward rvalid/rdata/rresp; handshake -> IDLE, rr pointer update as for WRESP.
- Unmapped access:
  - Write: awready and wready are pulsed together once the master's valids are high. Then bvalid=1, bresp=2'b11, held until bready.
  - Read: arready is pulsed; then rvalid=1, rresp=2'b11, rdata=0, held until rready.
  - No slave sees any valid.
- Signals to non-selected masters and slaves are 0. rdata/resp are 0 when valid is 0.
- A master dropping its valid before handshake is an AXI violation; behaviour is undefined and is not checked.
- A request arriving during a transaction waits. Arbitration only occurs in IDLE.
- Asynchronous reset mid-transaction returns to IDLE immediately. Outputs drop the same cycle; no response is generated.

Optional Feature:
- AXI_XBAR_TIMEOUT_EN defined:
  - A cycle counter clears on entry to WADDR/RADDR and counts through WRESP/RDATA.
  - On reaching TIMEOUT_CYC, all slave valids/readies are deasserted. The master receives bvalid (or rvalid with rdata=0), resp=2'b10 (SLVERR), held until its ready; then -> IDLE.
  - timeout_o sets and stays set until rst.
- Not defined: no counter; timeout_o tied 0; a stalled slave hangs the fabric.

Test Plan:
- M0 writes 0x1234_5678 to addr 0x1000_0004, slave 1 responds bresp=00 -> s1 sees awaddr 0x1000_0004, wstrb 4'hF; M0 gets bvalid, bresp=00; other slaves see no valid.
- M0 and M1 request reads in the same cycle, twice in a row -> grant order M0, M1, M0, M1; first arvalid to the slave appears 1 cycle after the request.
- With NS=3, M1 reads addr 0x5000_0000 -> arready pulse, then rvalid=1, rresp=11, rdata=0; no slave arvalid.
- Slave 2 gives awready 3 cycles before wready -> awvalid masked after its handshake; a single bvalid returns to the master.
- With AXI_XBAR_TIMEOUT_EN and TIMEOUT_CYC=8, slave 0 never asserts rvalid -> after 8 cycles M0 gets rresp=10 and timeout_o=1; a subsequent read to slave 1 completes normally.
- rst asserted during WRESP -> all outputs 0 in the same cycle; the next request is arbitrated from master 0.

Source files
------------

// File: rtl/axi4lite_xbar_nm.sv
// -----------------------------------------------------------------------------
// axi4lite_xbar_nm
//
// Shared-bus AXI4-Lite interconnect joining NM masters to NS slaves. A single
// transaction is in flight across the whole fabric. Masters are granted
// round-robin, and the slave is chosen by the top SEL_W address bits.
// Addresses that decode to a slave index >= NS complete locally with DECERR.
//
// Optional feature macro: AXI_XBAR_TIMEOUT_EN
//   Defined     : a transaction that runs TIMEOUT_CYC cycles without finishing
//                 is abandoned. The master gets SLVERR and timeout_o becomes a
//                 sticky 1 until rst.
//   Not defined : no watchdog; timeout_o is tied to 0.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   m_axi_*            NM master-side AXI4-Lite channels (master k at slice k)
//   s_axi_*            NS slave-side AXI4-Lite channels (slave s at slice s)
//   timeout_o          sticky timeout flag
//
// Handshake rule: a transfer happens on a rising clk edge where both valid and
// ready are high. After a valid is raised it is held until that edge. Every
// valid, ready, response and data output is 0 unless it belongs to the granted
// master or the selected slave. Response and read data are 0 while their valid
// is 0.
// -----------------------------------------------------------------------------
module axi4lite_xbar_nm #(
  parameter int NM          = 2,
  parameter int NS          = 16,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // master side
  input  logic [NM*AW-1:0]     m_axi_awaddr,
  input  logic [NM*AW-1:0]     m_axi_araddr,
  input  logic [NM*DW-1:0]     m_axi_wdata,
  input  logic [NM*DW/8-1:0]   m_axi_wstrb,
  input  logic [NM-1:0]        m_axi_awvalid,
  input  logic [NM-1:0]        m_axi_wvalid,
  input  logic [NM-1:0]        m_axi_bready,
  input  logic [NM-1:0]        m_axi_arvalid,
  input  logic [NM-1:0]        m_axi_rready,
  output logic [NM-1:0]        m_axi_awready,
  output logic [NM-1:0]        m_axi_wready,
  output logic [NM-1:0]        m_axi_bvalid,
  output logic [NM-1:0]        m_axi_arready,
  output logic [NM-1:0]        m_axi_rvalid,
  output logic [NM*2-1:0]      m_axi_bresp,
  output logic [NM*2-1:0]      m_axi_rresp,
  output logic [NM*DW-1:0]     m_axi_rdata,
  // slave side
  output logic [NS*AW-1:0]     s_axi_awaddr,
  output logic [NS*AW-1:0]     s_axi_araddr,
  output logic [NS*DW-1:0]     s_axi_wdata,
  output logic [NS*DW/8-1:0]   s_axi_wstrb,
  output logic [NS-1:0]        s_axi_awvalid,
  output logic [NS-1:0]        s_axi_wvalid,
  output logic [NS-1:0]        s_axi_bready,
  output logic [NS-1:0]        s_axi_arvalid,
  output logic [NS-1:0]        s_axi_rready,
  input  logic [NS-1:0]        s_axi_awready,
  input  logic [NS-1:0]        s_axi_wready,
  input  logic [NS-1:0]        s_axi_bvalid,
  input  logic [NS-1:0]        s_axi_arready,
  input  logic [NS-1:0]        s_axi_rvalid,
  input  logic [NS*2-1:0]      s_axi_bresp,
  input  logic [NS*2-1:0]      s_axi_rresp,
  input  logic [NS*DW-1:0]     s_axi_rdata,
  output logic                 timeout_o
);

  localparam int MW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    gnt_q, gnt_d;
  logic [MW-1:0]    rr_q, rr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             unmapped_q, unmapped_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;

  // ---------------------------------------------------------------------------
  // Arbitration: first requester at or after the round-robin pointer
  // ---------------------------------------------------------------------------
  logic [NM-1:0]    req;
  logic [MW-1:0]    win;
  logic             win_vld;
  logic [SEL_W-1:0] win_sel;

  assign req = m_axi_arvalid | (m_axi_awvalid & m_axi_wvalid);

  always_comb begin
    int idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < NM; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NM) idx = idx - NM;
      if (!win_vld && req[idx]) begin
        win     = MW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // A master presenting both a read and a write is served the read first.
  assign win_sel = m_axi_arvalid[win] ? m_axi_araddr[int'(win)*AW + AW - 1 -: SEL_W]
                                      : m_axi_awaddr[int'(win)*AW + AW - 1 -: SEL_W];

  // ---------------------------------------------------------------------------
  // Granted-master and selected-slave views
  // ---------------------------------------------------------------------------
  logic          g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic [AW-1:0] g_awaddr, g_araddr;
  logic [DW-1:0] g_wdata;
  logic [SW-1:0] g_wstrb;

  assign g_awvalid = m_axi_awvalid[gnt_q];
  assign g_wvalid  = m_axi_wvalid[gnt_q];
  assign g_bready  = m_axi_bready[gnt_q];
  assign g_arvalid = m_axi_arvalid[gnt_q];
  assign g_rready  = m_axi_rready[gnt_q];
  assign g_awaddr  = m_axi_awaddr[int'(gnt_q)*AW +: AW];
  assign g_araddr  = m_axi_araddr[int'(gnt_q)*AW +: AW];
  assign g_wdata   = m_axi_wdata[int'(gnt_q)*DW +: DW];
  assign g_wstrb   = m_axi_wstrb[int'(gnt_q)*SW +: SW];

  logic          sl_awready, sl_wready, sl_bvalid, sl_arready, sl_rvalid;
  logic [1:0]    sl_bresp, sl_rresp;
  logic [DW-1:0] sl_rdata;

  always_comb begin
    sl_awready = 1'b0;
    sl_wready  = 1'b0;
    sl_bvalid  = 1'b0;
    sl_arready = 1'b0;
    sl_rvalid  = 1'b0;
    sl_bresp   = 2'b00;
    sl_rresp   = 2'b00;
    sl_rdata   = '0;
    for (int s = 0; s < NS; s++) begin
      if (SEL_W'(s) == sel_q) begin
        sl_awready = s_axi_awready[s];
        sl_wready  = s_axi_wready[s];
        sl_bvalid  = s_axi_bvalid[s];
        sl_arready = s_axi_arready[s];
        sl_rvalid  = s_axi_rvalid[s];
        sl_bresp   = s_axi_bresp[s*2 +: 2];
        sl_rresp   = s_axi_rresp[s*2 +: 2];
        sl_rdata   = s_axi_rdata[s*DW +: DW];
      end
    end
  end

  logic [MW-1:0] rr_next;
  assign rr_next = (gnt_q == MW'(NM - 1)) ? '0 : gnt_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef AXI_XBAR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          to_hit;
  // The counter saturates at TIMEOUT_CYC, so to_hit stays high while the
  // error response waits for the master's ready.
  assign to_hit    = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYC));
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state and scalar channel intents
  // ---------------------------------------------------------------------------
  logic          o_s_awvalid, o_s_wvalid, o_s_bready, o_s_arvalid, o_s_rready;
  logic          o_s_wr_pay, o_s_rd_pay;
  logic          o_m_awready, o_m_wready, o_m_bvalid, o_m_arready, o_m_rvalid;
  logic [1:0]    o_m_bresp, o_m_rresp;
  logic [DW-1:0] o_m_rdata;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    sel_d       = sel_q;
    unmapped_d  = unmapped_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    o_s_awvalid = 1'b0;
    o_s_wvalid  = 1'b0;
    o_s_bready  = 1'b0;
    o_s_arvalid = 1'b0;
    o_s_rready  = 1'b0;
    o_s_wr_pay  = 1'b0;
    o_s_rd_pay  = 1'b0;
    o_m_awready = 1'b0;
    o_m_wready  = 1'b0;
    o_m_bvalid  = 1'b0;
    o_m_arready = 1'b0;
    o_m_rvalid  = 1'b0;
    o_m_bresp   = 2'b00;
    o_m_rresp   = 2'b00;
    o_m_rdata   = '0;
`ifdef AXI_XBAR_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (win_vld) begin
          gnt_d      = win;
          sel_d      = win_sel;
          unmapped_d = ({1'b0, win_sel} >= (SEL_W + 1)'(NS));
          state_d    = m_axi_arvalid[win] ? RADDR : WADDR;
        end
      end

      WADDR: begin
        if (unmapped_q) begin
          // Accept address and data together, then answer DECERR.
          if (g_awvalid && g_wvalid) begin
            o_m_awready = 1'b1;
            o_m_wready  = 1'b1;
            state_d     = WRESP;
          end
        end else begin
          // Each channel's valid is masked once it has handshaken, so the
          // slave never sees a second address or data beat.
          o_s_wr_pay  = 1'b1;
          o_s_awvalid = g_awvalid & ~aw_done_q;
          o_s_wvalid  = g_wvalid & ~w_done_q;
          o_m_awready = sl_awready & ~aw_done_q;
          o_m_wready  = sl_wready & ~w_done_q;
          aw_done_d   = aw_done_q | (o_s_awvalid & sl_awready);
          w_done_d    = w_done_q | (o_s_wvalid & sl_wready);
          if (aw_done_d && w_done_d) state_d = WRESP;
        end
      end

      WRESP: begin
        if (unmapped_q) begin
          o_m_bvalid = 1'b1;
          o_m_bresp  = 2'b11;
          if (g_bready) begin
            state_d = IDLE;
            rr_d    = rr_next;
          end
        end else begin
          o_s_bready = g_bready;
          o_m_bvalid = sl_bvalid;
          o_m_bresp  = sl_bvalid ? sl_bresp : 2'b00;
          if (sl_bvalid && g_bready) begin
            state_d = IDLE;
            rr_d    = rr_next;
          end
        end
      end

      RADDR: begin
        if (unmapped_q) begin
          o_m_arready = g_arvalid;
          if (g_arvalid) state_d = RDATA;
        end else begin
          o_s_rd_pay  = 1'b1;
          o_s_arvalid = g_arvalid;
          o_m_arready = sl_arready;
          if (g_arvalid && sl_arready) state_d = RDATA;
        end
      end

      RDATA: begin
        if (unmapped_q) begin
          o_m_rvalid = 1'b1;
          o_m_rresp  = 2'b11;
          if (g_rready) begin
            state_d = IDLE;
            rr_d    = rr_next;
          end
        end else begin
          o_s_rready = g_rready;
          o_m_rvalid = sl_rvalid;
          o_m_rresp  = sl_rvalid ? sl_rresp : 2'b00;
          o_m_rdata  = sl_rvalid ? sl_rdata : '0;
          if (sl_rvalid && g_rready) begin
            state_d = IDLE;
            rr_d    = rr_next;
          end
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef AXI_XBAR_TIMEOUT_EN
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!to_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Once expired the slave is cut off and the master is answered directly.
    if (to_hit) begin
      timeout_d   = 1'b1;
      state_d     = state_q;
      rr_d        = rr_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      o_s_awvalid = 1'b0;
      o_s_wvalid  = 1'b0;
      o_s_bready  = 1'b0;
      o_s_arvalid = 1'b0;
      o_s_rready  = 1'b0;
      o_s_wr_pay  = 1'b0;
      o_s_rd_pay  = 1'b0;
      o_m_awready = 1'b0;
      o_m_wready  = 1'b0;
      o_m_arready = 1'b0;
      o_m_bvalid  = 1'b0;
      o_m_rvalid  = 1'b0;
      o_m_bresp   = 2'b00;
      o_m_rresp   = 2'b00;
      o_m_rdata   = '0;
      if (state_q == WADDR || state_q == WRESP) begin
        o_m_bvalid = 1'b1;
        o_m_bresp  = 2'b10;
        if (g_bready) begin
          state_d = IDLE;
          rr_d    = rr_next;
        end
      end else begin
        o_m_rvalid = 1'b1;
        o_m_rresp  = 2'b10;
        if (g_rready) begin
          state_d = IDLE;
          rr_d    = rr_next;
        end
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Steer the scalar intents onto the granted master and selected slave
  // ---------------------------------------------------------------------------
  always_comb begin
    m_axi_awready = '0;
    m_axi_wready  = '0;
    m_axi_bvalid  = '0;
    m_axi_arready = '0;
    m_axi_rvalid  = '0;
    m_axi_bresp   = '0;
    m_axi_rresp   = '0;
    m_axi_rdata   = '0;
    for (int k = 0; k < NM; k++) begin
      if (MW'(k) == gnt_q) begin
        m_axi_awready[k]        = o_m_awready;
        m_axi_wready[k]         = o_m_wready;
        m_axi_bvalid[k]         = o_m_bvalid;
        m_axi_arready[k]        = o_m_arready;
        m_axi_rvalid[k]         = o_m_rvalid;
        m_axi_bresp[k*2 +: 2]   = o_m_bresp;
        m_axi_rresp[k*2 +: 2]   = o_m_rresp;
        m_axi_rdata[k*DW +: DW] = o_m_rdata;
      end
    end
  end

  always_comb begin
    s_axi_awaddr  = '0;
    s_axi_araddr  = '0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_awvalid = '0;
    s_axi_wvalid  = '0;
    s_axi_bready  = '0;
    s_axi_arvalid = '0;
    s_axi_rready  = '0;
    for (int s = 0; s < NS; s++) begin
      if (!unmapped_q && (SEL_W'(s) == sel_q)) begin
        s_axi_awvalid[s] = o_s_awvalid;
        s_axi_wvalid[s]  = o_s_wvalid;
        s_axi_bready[s]  = o_s_bready;
        s_axi_arvalid[s] = o_s_arvalid;
        s_axi_rready[s]  = o_s_rready;
        if (o_s_wr_pay) begin
          s_axi_awaddr[s*AW +: AW] = g_awaddr;
          s_axi_wdata[s*DW +: DW]  = g_wdata;
          s_axi_wstrb[s*SW +: SW]  = g_wstrb;
        end
        if (o_s_rd_pay) begin
          s_axi_araddr[s*AW +: AW] = g_araddr;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      sel_q      <= '0;
      unmapped_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      sel_q      <= sel_d;
      unmapped_q <= unmapped_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

`ifdef AXI_XBAR_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_axi4lite_xbar_nm.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_xbar_nm
//
// Directed bench for axi4lite_xbar_nm with NM=2, NS=3 (slave indices 3..15
// are unmapped). Inputs change 1 ns after the rising edge; outputs are checked
// in that same window, away from the edge.
// -----------------------------------------------------------------------------
module tb_axi4lite_xbar_nm;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // master side
  logic [NM*AW-1:0]   m_awaddr, m_araddr;
  logic [NM*DW-1:0]   m_wdata;
  logic [NM*DW/8-1:0] m_wstrb;
  logic [NM-1:0]      m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [NM-1:0]      m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [NM*2-1:0]    m_bresp, m_rresp;
  logic [NM*DW-1:0]   m_rdata;
  // slave side
  logic [NS*AW-1:0]   s_awaddr, s_araddr;
  logic [NS*DW-1:0]   s_wdata;
  logic [NS*DW/8-1:0] s_wstrb;
  logic [NS-1:0]      s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [NS-1:0]      s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [NS*2-1:0]    s_bresp, s_rresp;
  logic [NS*DW-1:0]   s_rdata;
  logic               timeout;

  axi4lite_xbar_nm #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW), .SEL_W(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_axi_awaddr(m_awaddr), .m_axi_araddr(m_araddr),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_awvalid(m_awvalid), .m_axi_wvalid(m_wvalid), .m_axi_bready(m_bready),
    .m_axi_arvalid(m_arvalid), .m_axi_rready(m_rready),
    .m_axi_awready(m_awready), .m_axi_wready(m_wready), .m_axi_bvalid(m_bvalid),
    .m_axi_arready(m_arready), .m_axi_rvalid(m_rvalid),
    .m_axi_bresp(m_bresp), .m_axi_rresp(m_rresp), .m_axi_rdata(m_rdata),
    .s_axi_awaddr(s_awaddr), .s_axi_araddr(s_araddr),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb),
    .s_axi_awvalid(s_awvalid), .s_axi_wvalid(s_wvalid), .s_axi_bready(s_bready),
    .s_axi_arvalid(s_arvalid), .s_axi_rready(s_rready),
    .s_axi_awready(s_awready), .s_axi_wready(s_wready), .s_axi_bvalid(s_bvalid),
    .s_axi_arready(s_arready), .s_axi_rvalid(s_rvalid),
    .s_axi_bresp(s_bresp), .s_axi_rresp(s_rresp), .s_axi_rdata(s_rdata),
    .timeout_o(timeout)
  );

  // OR of every DUT output, used where everything must be quiet
  logic all_out_any;
  assign all_out_any = |{m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                         m_bresp, m_rresp, m_rdata,
                         s_awaddr, s_araddr, s_wdata, s_wstrb,
                         s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
                         timeout};

  int n_cmp = 0;
  int n_err = 0;

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0;
    m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
    s_awready = '0; s_wready = '0; s_bvalid = '0; s_arready = '0; s_rvalid = '0;
    s_bresp = '0; s_rresp = '0; s_rdata = '0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // global guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    clear_inputs();
    rst = 1'b1;
    repeat (2) tick();

    // ---------------- reset: everything quiet even with requests present
    m_arvalid = 2'b11; m_awvalid = 2'b11; m_wvalid = 2'b11;
    #1;
    chk("rst_outputs_zero", all_out_any, 1'b0);
    clear_inputs();
    tick();
    rst = 1'b0;

    // ---------------- A: simultaneous reads, round-robin M0,M1,M0,M1
    m_araddr  = {32'h2000_0020, 32'h0000_0010};
    m_arvalid = 2'b11;
    m_rready  = 2'b11;
    #1;
    chk("idle_no_arready", m_arready, 2'b00);
    chk("idle_no_s_arvalid", s_arvalid, 3'b000);
    tick();                                   // M0 granted, slave 0
    chk("rd1_s_arvalid", s_arvalid, 3'b001);
    chk("rd1_s_araddr", s_araddr, {64'h0, 32'h0000_0010});
    s_arready = 3'b001;
    #1;
    chk("rd1_m_arready", m_arready, 2'b01);
    tick();                                   // RDATA
    s_arready = '0;
    m_arvalid = 2'b10;
    s_rdata   = {32'hB0B0_0002, 32'h0, 32'hA0A0_0000};
    s_rresp   = 6'b01_00_00;
    s_rvalid  = 3'b001;
    #1;
    chk("rd1_m_rvalid", m_rvalid, 2'b01);
    chk("rd1_m_rdata", m_rdata, 64'h0000_0000_A0A0_0000);
    tick();                                   // done, pointer -> 1
    s_rvalid  = '0;
    m_arvalid = 2'b11;
    tick();                                   // both request: M1 must win
    chk("rd2_s_arvalid", s_arvalid, 3'b100);
    chk("rd2_s_araddr", s_araddr[95:64], 32'h2000_0020);
    s_arready = 3'b100;
    tick();
    s_arready = '0;
    m_arvalid = 2'b01;
    s_rvalid  = 3'b100;
    #1;
    chk("rd2_m_rvalid", m_rvalid, 2'b10);
    chk("rd2_m_rresp", m_rresp, 4'b0100);
    chk("rd2_m_rdata", m_rdata, 64'hB0B0_0002_0000_0000);
    tick();                                   // pointer -> 0
    s_rvalid  = '0;
    m_arvalid = 2'b11;
    tick();
    chk("rd3_s_arvalid", s_arvalid, 3'b001);
    s_arready = 3'b001;
    tick();
    s_arready = '0;
    m_arvalid = 2'b10;
    s_rvalid  = 3'b001;
    tick();                                   // pointer -> 1
    s_rvalid  = '0;
    tick();
    chk("rd4_s_arvalid", s_arvalid, 3'b100);
    s_arready = 3'b100;
    tick();
    s_arready = '0;
    m_arvalid = 2'b00;
    s_rvalid  = 3'b100;
    tick();                                   // pointer -> 0
    clear_inputs();

    // ---------------- B: M0 writes 0x1234_5678 to 0x1000_0004 (slave 1)
    m_awaddr  = {32'h0, 32'h1000_0004};
    m_wdata   = {32'h0, 32'h1234_5678};
    m_wstrb   = 8'h0F;
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01;
    #1;
    chk("idle_no_awready", m_awready, 2'b00);
    tick();
    chk("wr_s_awvalid", s_awvalid, 3'b010);
    chk("wr_s_wvalid", s_wvalid, 3'b010);
    chk("wr_s_awaddr", s_awaddr, {32'h0, 32'h1000_0004, 32'h0});
    chk("wr_s_wdata", s_wdata, {32'h0, 32'h1234_5678, 32'h0});
    chk("wr_s_wstrb", s_wstrb, 12'h0F0);
    s_awready = 3'b010; s_wready = 3'b010;
    #1;
    chk("wr_m_awready", m_awready, 2'b01);
    chk("wr_m_wready", m_wready, 2'b01);
    tick();                                   // WRESP
    s_awready = '0; s_wready = '0; m_awvalid = '0; m_wvalid = '0;
    #1;
    chk("wr_s_bready", s_bready, 3'b010);
    chk("wr_no_bvalid_yet", m_bvalid, 2'b00);
    s_bresp  = 6'b10_00_10;                   // neighbours carry junk
    s_bvalid = 3'b010;
    #1;
    chk("wr_m_bvalid", m_bvalid, 2'b01);
    chk("wr_m_bresp", m_bresp, 4'b0000);
    tick();                                   // pointer -> 1
    clear_inputs();
    #1;
    chk("wr_bvalid_dropped", m_bvalid, 2'b00);

    // ---------------- C: M1 reads unmapped 0x5000_0000
    m_araddr  = {32'h5000_0000, 32'h0};
    m_arvalid = 2'b10;
    s_arready = 3'b111; s_rvalid = 3'b111;
    s_rresp   = 6'b01_01_01;
    s_rdata   = {3{32'hDEAD_BEEF}};
    tick();
    chk("um_rd_m_arready", m_arready, 2'b10);
    chk("um_rd_no_s_arvalid", s_arvalid, 3'b000);
    tick();
    m_arvalid = '0;
    #1;
    chk("um_rd_m_rvalid", m_rvalid, 2'b10);
    chk("um_rd_m_rresp", m_rresp, 4'b1100);
    chk("um_rd_m_rdata", m_rdata, 64'h0);
    chk("um_rd_no_s_rready", s_rready, 3'b000);
    tick();                                   // rready low: response held
    chk("um_rd_rvalid_held", m_rvalid, 2'b10);
    m_rready = 2'b10;
    tick();                                   // pointer -> 0
    chk("um_rd_done", m_rvalid, 2'b00);
    clear_inputs();

    // ---------------- E: M1 write to slave 2, awready 3 cycles before wready
    m_awaddr  = {32'h2000_0008, 32'h0};
    m_wdata   = {32'hCAFE_F00D, 32'h0};
    m_wstrb   = 8'h30;
    m_awvalid = 2'b10; m_wvalid = 2'b10; m_bready = 2'b10;
    tick();
    chk("split_s_awvalid", s_awvalid, 3'b100);
    chk("split_s_wvalid", s_wvalid, 3'b100);
    chk("split_s_wstrb", s_wstrb, 12'h300);
    chk("split_s_wdata", s_wdata[95:64], 32'hCAFE_F00D);
    s_awready = 3'b100;
    #1;
    chk("split_m_awready", m_awready, 2'b10);
    chk("split_m_wready_low", m_wready, 2'b00);
    tick();                                   // address accepted
    chk("split_awvalid_masked", s_awvalid, 3'b000);
    chk("split_wvalid_held", s_wvalid, 3'b100);
    chk("split_awready_masked", m_awready, 2'b00);
    tick();
    tick();
    s_wready = 3'b100;
    #1;
    chk("split_m_wready", m_wready, 2'b10);
    tick();                                   // WRESP
    s_awready = '0; s_wready = '0; m_awvalid = '0; m_wvalid = '0;
    s_bvalid  = 3'b100;
    #1;
    chk("split_m_bvalid", m_bvalid, 2'b10);
    tick();                                   // slave still shows bvalid
    chk("split_single_bvalid", m_bvalid, 2'b00);
    clear_inputs();

    // ---------------- D: M0 writes unmapped 0x7000_0000
    m_awaddr  = {32'h0, 32'h7000_0000};
    m_awvalid = 2'b01; m_wvalid = 2'b01;
    s_awready = 3'b111; s_wready = 3'b111; s_bvalid = 3'b111;
    tick();
    chk("um_wr_m_awready", m_awready, 2'b01);
    chk("um_wr_m_wready", m_wready, 2'b01);
    chk("um_wr_no_s_valid", {s_awvalid, s_wvalid}, 6'b000000);
    tick();
    m_awvalid = '0; m_wvalid = '0;
    #1;
    chk("um_wr_m_bvalid", m_bvalid, 2'b01);
    chk("um_wr_m_bresp", m_bresp, 4'b0011);
    chk("um_wr_no_s_bready", s_bready, 3'b000);
    m_bready = 2'b01;
    tick();                                   // pointer -> 1
    clear_inputs();

    // ---------------- F: reset during WRESP, pointer returns to M0
    m_awaddr  = {32'h2000_0008, 32'h0};
    m_awvalid = 2'b10; m_wvalid = 2'b10; m_bready = 2'b10;
    s_awready = 3'b100; s_wready = 3'b100;
    tick();                                   // WADDR
    tick();                                   // WRESP
    s_awready = '0; s_wready = '0; m_awvalid = '0; m_wvalid = '0;
    #1;
    chk("rst_pre_s_bready", s_bready, 3'b100);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs_zero", all_out_any, 1'b0);
    tick();
    clear_inputs();
    tick();
    m_araddr  = {32'h2000_0020, 32'h0000_0010};
    m_arvalid = 2'b11;
    m_rready  = 2'b11;
    rst = 1'b0;
    tick();
    chk("rst_rr_m0_first", s_arvalid, 3'b001);
    s_arready = 3'b001;
    tick();
    s_arready = '0;
    m_arvalid = 2'b00;
    s_rvalid  = 3'b001;
    tick();
    clear_inputs();
    tick();

`ifdef AXI_XBAR_TIMEOUT_EN
    // ---------------- G: slave 0 never answers the read
    m_araddr  = {32'h0, 32'h0000_0010};
    m_arvalid = 2'b01; m_rready = 2'b01;
    s_arready = 3'b001;
    tick();                                   // RADDR, counter cleared
    n = 0;
    while (!m_rvalid[0] && n < 30) begin
      tick();
      n++;
      if (n == 1) m_arvalid = '0;
    end
    chk("to_latency", n, 8);
    chk("to_m_rresp", m_rresp, 4'b0010);
    chk("to_m_rdata", m_rdata, 64'h0);
    chk("to_s_quiet", {s_arvalid, s_rready}, 6'b000000);
    tick();
    chk("to_sticky_set", timeout, 1'b1);
    s_arready = '0;
    m_araddr  = {32'h0, 32'h1000_0040};
    m_arvalid = 2'b01;
    s_arready = 3'b010;
    s_rdata   = {32'h0, 32'h5555_AAAA, 32'h0};
    tick();
    tick();
    m_arvalid = '0;
    s_rvalid  = 3'b010;
    #1;
    chk("to_next_rd_rvalid", m_rvalid, 2'b01);
    chk("to_next_rd_rdata", m_rdata, 64'h0000_0000_5555_AAAA);
    tick();
    clear_inputs();
    chk("to_sticky_held", timeout, 1'b1);
`else
    n = 0;
    chk("timeout_tied_low", timeout, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
